// File: rtl/calc_key_entry.sv
`default_nettype none
// ============================================================================
// Module      : calc_key_entry
// Description : Key entry, evaluation and character-buffer formatting for the
//               calculator text-LCD path (A op B = result).
// Revision    : 1.0 - initial release
// ============================================================================
module calc_key_entry #(
    parameter int SAMPLE_DIV = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       swp0,
    input  logic       swp1,
    input  logic       swp2,
    input  logic       swp3,
    input  logic       swp4,
    input  logic       swp5,
    input  logic       swp6,
    input  logic       swp7,
    input  logic       swp8,
    input  logic       swp9,
    input  logic       lrd,
    input  logic [7:0] swd,
    input  logic [4:0] char_addr,
    output logic [7:0] char_data,
    output logic       busy,
    output logic [7:0] led
);
    typedef enum logic [2:0] {
        ST_ENTA    = 3'd0,
        ST_ENTB    = 3'd1,
        ST_CALC    = 3'd2,
        ST_CONVERT = 3'd3,
        ST_DONE    = 3'd4,
        ST_ERR     = 3'd5
    } state_t;

    localparam int         c_cnt_w  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [7:0] c_blank  = 8'h20;
    localparam logic [7:0] c_eq     = 8'h3D;
    localparam logic [7:0] c_minus  = 8'h2D;
    localparam logic [1:0] c_op_add = 2'd0;
    localparam logic [1:0] c_op_sub = 2'd1;
    localparam logic [1:0] c_op_mul = 2'd2;
    localparam logic [1:0] c_op_div = 2'd3;

    function automatic logic [7:0] op_char(input logic [1:0] op);
        case (op)
            c_op_add: op_char = 8'h2B;
            c_op_sub: op_char = 8'h2D;
            c_op_mul: op_char = 8'hD7;
            default:  op_char = 8'hF7;
        endcase
    endfunction

    state_t             r_state, w_state_next;
    logic [c_cnt_w-1:0] r_div_cnt;
    logic               w_strobe;
    logic [9:0]         w_swp, r_prev_swp, w_dig_rise;
    logic               r_prev_lrd;
    logic [4:0]         w_op_lvl, r_prev_op;
    logic               w_clr_ev, w_dig_ev, w_op_ev, w_op_onehot, w_op_is_eq;
    logic [3:0]         w_dig_val;
    logic [1:0]         w_op_code;

    logic [13:0] r_a, r_b, w_acc, w_acc_next;
    logic [2:0]  r_count;
    logic [3:0]  r_pos, r_op_pos;
    logic [1:0]  r_op;
    logic        r_neg, w_neg_res;
    logic [26:0] r_mag, w_mag_res;
    logic [31:0] r_bcd, w_bcd_adj, w_bcd_next;
    logic [4:0]  r_cyc;
    logic [13:0] r_rem, w_rem_next, r_quo, w_quo_next;
    logic [14:0] w_div_shift;
    logic [15:0] w_div_trial;
    logic [7:0]  r_buf [32];
    logic [7:0]  w_line2 [16];
    logic [3:0]  w_unused;

    assign w_unused = {^swd[2:0], w_div_shift[14], w_div_trial[14], w_bcd_adj[31]};

    // ---------------- key sampling ----------------
    assign w_strobe = (r_div_cnt == c_cnt_w'(SAMPLE_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div_cnt <= '0;
        end else if (w_strobe) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + c_cnt_w'(1);
        end
    end

    assign w_swp    = {swp9, swp8, swp7, swp6, swp5, swp4, swp3, swp2, swp1, swp0};
    assign w_op_lvl = swd[7:3];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev_swp <= '0;
            r_prev_lrd <= 1'b0;
            r_prev_op  <= '0;
        end else if (w_strobe) begin
            r_prev_swp <= w_swp;
            r_prev_lrd <= lrd;
            r_prev_op  <= w_op_lvl;
        end
    end

    assign w_dig_rise  = w_swp & ~r_prev_swp;
    assign w_clr_ev    = w_strobe & lrd & ~r_prev_lrd;
    assign w_dig_ev    = w_strobe & ~w_clr_ev & (|w_dig_rise);
    assign w_op_onehot = (w_op_lvl != 5'd0) && ((w_op_lvl & (w_op_lvl - 5'd1)) == 5'd0);
    assign w_op_ev     = w_strobe & ~w_clr_ev & ~(|w_dig_rise) & w_op_onehot
                         & (|(w_op_lvl & ~r_prev_op));
    assign w_op_is_eq  = w_op_lvl[0];
    assign w_op_code   = w_op_lvl[4] ? c_op_add :
                         w_op_lvl[3] ? c_op_sub :
                         w_op_lvl[2] ? c_op_mul : c_op_div;

    always_comb begin
        w_dig_val = 4'd0;
        for (int i = 9; i >= 0; i--) begin
            if (w_dig_rise[i]) w_dig_val = 4'(i);
        end
    end

    assign w_acc      = (r_state == ST_ENTA) ? r_a : r_b;
    assign w_acc_next = w_acc * 14'd10 + {10'd0, w_dig_val};

    // ---------------- arithmetic ----------------
    assign w_div_shift = {r_rem, r_quo[13]};
    assign w_div_trial = {1'b0, w_div_shift} - {2'b00, r_b};
    assign w_rem_next  = w_div_trial[15] ? w_div_shift[13:0] : w_div_trial[13:0];
    assign w_quo_next  = {r_quo[12:0], ~w_div_trial[15]};

    always_comb begin
        w_neg_res = 1'b0;
        w_mag_res = 27'(w_quo_next);
        case (r_op)
            c_op_add: w_mag_res = 27'(r_a) + 27'(r_b);
            c_op_sub: begin
                if (r_a >= r_b) begin
                    w_mag_res = 27'(r_a - r_b);
                end else begin
                    w_mag_res = 27'(r_b - r_a);
                    w_neg_res = 1'b1;
                end
            end
            c_op_mul: w_mag_res = 27'(r_a) * 27'(r_b);
            default:  w_mag_res = 27'(w_quo_next);
        endcase
    end

    // ---------------- binary to BCD ----------------
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_dabble
            assign w_bcd_adj[4*gi +: 4] = (r_bcd[4*gi +: 4] >= 4'd5) ?
                                          r_bcd[4*gi +: 4] + 4'd3 : r_bcd[4*gi +: 4];
        end
    endgenerate

    assign w_bcd_next = {w_bcd_adj[30:0], r_mag[26]};

    // Right-aligned result with leading-zero blanking and a floating minus sign.
    always_comb begin
        logic       v_seen;
        int         v_msd;
        logic [3:0] v_d;
        v_seen = 1'b0;
        v_msd  = 0;
        v_d    = 4'd0;
        for (int j = 0; j < 16; j++) w_line2[j] = c_blank;
        for (int i = 7; i >= 0; i--) begin
            v_d = w_bcd_next[4*i +: 4];
            if (!v_seen && (v_d != 4'd0 || i == 0)) begin
                v_seen = 1'b1;
                v_msd  = i;
            end
            if (v_seen) w_line2[15-i] = {4'h3, v_d};
        end
        if (r_neg) w_line2[14-v_msd] = c_minus;
    end

    // ---------------- control ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_ENTA;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        if (w_clr_ev) begin
            w_state_next = ST_ENTA;
        end else begin
            case (r_state)
                ST_ENTA:
                    if (w_op_ev && !w_op_is_eq && r_count != 3'd0) w_state_next = ST_ENTB;
                ST_ENTB:
                    if (w_op_ev && w_op_is_eq && r_count != 3'd0) w_state_next = ST_CALC;
                ST_CALC: begin
                    if (r_op != c_op_div)       w_state_next = ST_CONVERT;
                    else if (r_b == 14'd0)      w_state_next = ST_ERR;
                    else if (r_cyc == 5'd13)    w_state_next = ST_CONVERT;
                end
                ST_CONVERT:
                    if (r_cyc == 5'd26) w_state_next = ST_DONE;
                ST_DONE, ST_ERR:
                    if (w_dig_ev) w_state_next = ST_ENTA;
                default: w_state_next = ST_ENTA;
            endcase
        end
    end

    // ---------------- datapath and display buffer ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_count  <= '0;
            r_pos    <= '0;
            r_op_pos <= '0;
            r_op     <= c_op_add;
            r_neg    <= 1'b0;
            r_mag    <= '0;
            r_bcd    <= '0;
            r_cyc    <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            for (int i = 0; i < 32; i++) r_buf[i] <= c_blank;
        end else if (w_clr_ev) begin
            r_a     <= '0;
            r_b     <= '0;
            r_count <= '0;
            r_pos   <= '0;
            for (int i = 0; i < 32; i++) r_buf[i] <= c_blank;
        end else begin
            case (r_state)
                ST_ENTA, ST_ENTB: begin
                    if (w_dig_ev && r_count < 3'd4) begin
                        if (r_state == ST_ENTA) r_a <= w_acc_next;
                        else                    r_b <= w_acc_next;
                        r_buf[{1'b0, r_pos}] <= {4'h3, w_dig_val};
                        r_pos   <= r_pos + 4'd1;
                        r_count <= r_count + 3'd1;
                    end else if (w_op_ev && !w_op_is_eq) begin
                        if (r_state == ST_ENTA && r_count != 3'd0) begin
                            r_op                 <= w_op_code;
                            r_op_pos             <= r_pos;
                            r_buf[{1'b0, r_pos}] <= op_char(w_op_code);
                            r_pos                <= r_pos + 4'd1;
                            r_count              <= '0;
                        end else if (r_state == ST_ENTB && r_count == 3'd0) begin
                            r_op                    <= w_op_code;
                            r_buf[{1'b0, r_op_pos}] <= op_char(w_op_code);
                        end
                    end else if (w_op_ev && w_op_is_eq && r_state == ST_ENTB
                                 && r_count != 3'd0) begin
                        r_buf[{1'b0, r_pos}] <= c_eq;
                        r_pos   <= r_pos + 4'd1;
                        r_count <= '0;
                        r_cyc   <= '0;
                        r_rem   <= '0;
                        r_quo   <= r_a;
                    end
                end
                ST_CALC: begin
                    if (r_op == c_op_div && r_b == 14'd0) begin
                        for (int j = 16; j < 32; j++) r_buf[j] <= c_blank;
                        r_buf[16] <= 8'h45;
                        r_buf[17] <= 8'h72;
                        r_buf[18] <= 8'h72;
                    end else if (r_op == c_op_div && r_cyc != 5'd13) begin
                        r_rem <= w_rem_next;
                        r_quo <= w_quo_next;
                        r_cyc <= r_cyc + 5'd1;
                    end else begin
                        r_mag <= w_mag_res;
                        r_neg <= w_neg_res;
                        r_bcd <= '0;
                        r_cyc <= '0;
                    end
                end
                ST_CONVERT: begin
                    r_bcd <= w_bcd_next;
                    r_mag <= {r_mag[25:0], 1'b0};
                    r_cyc <= r_cyc + 5'd1;
                    if (r_cyc == 5'd26) begin
                        for (int j = 0; j < 16; j++) r_buf[16+j] <= w_line2[j];
                    end
                end
                ST_DONE, ST_ERR: begin
                    if (w_dig_ev) begin
                        for (int i = 0; i < 32; i++) r_buf[i] <= c_blank;
                        r_buf[0] <= {4'h3, w_dig_val};
                        r_a      <= {10'd0, w_dig_val};
                        r_b      <= '0;
                        r_count  <= 3'd1;
                        r_pos    <= 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) char_data <= c_blank;
        else     char_data <= r_buf[char_addr];
    end

    assign busy = (r_state == ST_CALC) || (r_state == ST_CONVERT);
    assign led  = {1'b0, r_count, (r_state == ST_ERR), r_state};

endmodule
`default_nettype wire

// File: tb/tb_calc_key_entry.sv
`default_nettype none
// ============================================================================
// Module      : tb_calc_key_entry
// Description : Self-checking bench for calc_key_entry (buffer scoreboard).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_calc_key_entry;
    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       lrd = 1'b0;
    logic [9:0] swp = '0;
    logic [7:0] swd = '0;
    logic [4:0] char_addr = '0;
    logic [7:0] char_data, led;
    logic       busy;
    int         checks = 0;
    int         errors = 0;

    typedef struct packed {
        logic [4:0] addr;
        logic [7:0] data;
    } exp_t;
    exp_t sb[$];

    calc_key_entry #(.SAMPLE_DIV(DIV)) dut (
        .clk(clk), .rst(rst),
        .swp0(swp[0]), .swp1(swp[1]), .swp2(swp[2]), .swp3(swp[3]), .swp4(swp[4]),
        .swp5(swp[5]), .swp6(swp[6]), .swp7(swp[7]), .swp8(swp[8]), .swp9(swp[9]),
        .lrd(lrd), .swd(swd), .char_addr(char_addr), .char_data(char_data),
        .busy(busy), .led(led)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1);
    end

    function automatic logic [7:0] map_char(input byte c);
        if (c == "*") return 8'hD7;
        if (c == "/") return 8'hF7;
        return c;
    endfunction

    // Expected picture of both lines: line 1 left-aligned, line 2 right-aligned
    // unless l2_left is set.
    function automatic void push_lines(input string l1, input string l2, input bit l2_left);
        exp_t e;
        int   k;
        for (int i = 0; i < 32; i++) begin
            e.addr = 5'(i);
            e.data = 8'h20;
            if (i < 16) begin
                if (i < l1.len()) e.data = map_char(l1[i]);
            end else begin
                k = l2_left ? i - 16 : i - 32 + l2.len();
                if (k >= 0 && k < l2.len()) e.data = map_char(l2[k]);
            end
            sb.push_back(e);
        end
    endfunction

    task automatic read_cell(input logic [4:0] a, output logic [7:0] d);
        @(negedge clk);
        char_addr = a;
        @(negedge clk);
        d = char_data;
    endtask

    task automatic tap_digit(input int d);
        @(negedge clk);
        swp[d] = 1'b1;
        repeat (2*DIV) @(negedge clk);
        swp[d] = 1'b0;
        repeat (2*DIV) @(negedge clk);
    endtask

    task automatic tap_op(input logic [7:0] s);
        @(negedge clk);
        swd = s;
        repeat (2*DIV) @(negedge clk);
        swd = 8'h00;
        repeat (2*DIV) @(negedge clk);
    endtask

    task automatic tap_clear();
        @(negedge clk);
        lrd = 1'b1;
        repeat (2*DIV) @(negedge clk);
        lrd = 1'b0;
        repeat (2*DIV) @(negedge clk);
    endtask

    task automatic enter_number(input int v);
        string s;
        s = $sformatf("%0d", v);
        for (int i = 0; i < s.len(); i++) tap_digit(int'(s[i]) - 48);
    endtask

    // Presses '=' and returns cycles from busy rising until busy falls (-1 on timeout).
    task automatic do_equals(input int hold_digit, output int lat);
        @(negedge clk);
        swd = 8'h08;
        lat = -1;
        for (int n = 0; n < 4*DIV && !busy; n++) @(negedge clk);
        if (busy) begin
            if (hold_digit >= 0) swp[hold_digit] = 1'b1;
            for (int n = 0; n < 100; n++) begin
                @(negedge clk);
                if (!busy) begin
                    lat = n + 1;
                    break;
                end
            end
        end
        swd = 8'h00;
        repeat (2*DIV) @(negedge clk);
    endtask

    task automatic test_reset();
        exp_t       e;
        logic [7:0] got;
        repeat (3) @(negedge clk);
        checks++;
        if (led !== 8'h00) begin errors++; $display("FAIL reset_led: got %h expected 00", led); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++;
        if (char_data !== 8'h20) begin errors++; $display("FAIL reset_char: got %h expected 20", char_data); end
        rst = 1'b0;
        push_lines("", "", 1'b0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            read_cell(e.addr, got);
            checks++;
            if (got !== e.data) begin errors++; $display("FAIL reset_cell %0d: got %h expected %h", e.addr, got, e.data); end
        end
    endtask

    task automatic test_add();
        exp_t       e;
        logic [7:0] got;
        int         lat;
        enter_number(12); tap_op(8'h80); enter_number(34);
        do_equals(-1, lat);
        checks++;
        if (lat !== 28) begin errors++; $display("FAIL add_latency: got %0d expected 28", lat); end
        checks++;
        if (led[2:0] !== 3'd4) begin errors++; $display("FAIL add_state: got %0d expected 4", led[2:0]); end
        push_lines("12+34=", "46", 1'b0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            read_cell(e.addr, got);
            checks++;
            if (got !== e.data) begin errors++; $display("FAIL add_cell %0d: got %h expected %h", e.addr, got, e.data); end
        end
    endtask

    task automatic test_sub();
        exp_t       e;
        logic [7:0] got;
        int         lat;
        tap_clear();
        checks++;
        if (led !== 8'h00) begin errors++; $display("FAIL clear_led: got %h expected 00", led); end
        tap_digit(7); tap_op(8'h40); tap_digit(9);
        do_equals(-1, lat);
        checks++;
        if (lat !== 28) begin errors++; $display("FAIL sub_latency: got %0d expected 28", lat); end
        checks++;
        if (led[2:0] !== 3'd4) begin errors++; $display("FAIL sub_state: got %0d expected 4", led[2:0]); end
        push_lines("7-9=", $sformatf("%0d", 7 - 9), 1'b0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            read_cell(e.addr, got);
            checks++;
            if (got !== e.data) begin errors++; $display("FAIL sub_cell %0d: got %h expected %h", e.addr, got, e.data); end
        end
    endtask

    task automatic test_mul();
        exp_t       e;
        logic [7:0] got;
        int         lat;
        tap_clear();
        enter_number(9999); tap_op(8'h20); enter_number(9999);
        do_equals(-1, lat);
        checks++;
        if (lat !== 28) begin errors++; $display("FAIL mul_latency: got %0d expected 28", lat); end
        push_lines("9999*9999=", $sformatf("%0d", 9999 * 9999), 1'b0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            read_cell(e.addr, got);
            checks++;
            if (got !== e.data) begin errors++; $display("FAIL mul_cell %0d: got %h expected %h", e.addr, got, e.data); end
        end
    endtask

    task automatic test_div();
        exp_t       e;
        logic [7:0] got;
        int         lat;
        tap_clear();
        enter_number(100); tap_op(8'h10); enter_number(7);
        do_equals(-1, lat);
        checks++;
        if (lat !== 41) begin errors++; $display("FAIL div_latency: got %0d expected 41", lat); end
        push_lines("100/7=", $sformatf("%0d", 100 / 7), 1'b0);
        tap_clear();
        tap_digit(5); tap_op(8'h10); tap_digit(0);
        do_equals(-1, lat);
        checks++;
        if (lat !== 1) begin errors++; $display("FAIL div0_latency: got %0d expected 1", lat); end
        checks++;
        if (led[3:0] !== 4'hD) begin errors++; $display("FAIL div0_led: got %h expected d", led[3:0]); end
        push_lines("5/0=", "Err", 1'b1);
        // The first picture was overwritten by the divide-by-zero run; keep only the second.
        for (int i = 0; i < 32; i++) void'(sb.pop_front());
        while (sb.size() > 0) begin
            e = sb.pop_front();
            read_cell(e.addr, got);
            checks++;
            if (got !== e.data) begin errors++; $display("FAIL div_cell %0d: got %h expected %h", e.addr, got, e.data); end
        end
    endtask

    task automatic test_entry_edges();
        exp_t       e;
        logic [7:0] got;
        int         lat;
        for (int d = 1; d <= 5; d++) tap_digit(d);
        checks++;
        if (led !== 8'h40) begin errors++; $display("FAIL five_digits_led: got %h expected 40", led); end
        tap_op(8'h80); tap_digit(1);
        do_equals(-1, lat);
        push_lines("1234+1=", $sformatf("%0d", 1234 + 1), 1'b0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            read_cell(e.addr, got);
            checks++;
            if (got !== e.data) begin errors++; $display("FAIL five_digits_cell %0d: got %h expected %h", e.addr, got, e.data); end
        end
        tap_clear();
        tap_digit(1); tap_op(8'h80); tap_digit(1);
        do_equals(7, lat);
        repeat (3*DIV) @(negedge clk);
        checks++;
        if (led[2:0] !== 3'd4) begin errors++; $display("FAIL held_key_state: got %0d expected 4", led[2:0]); end
        swp[7] = 1'b0;
        repeat (2*DIV) @(negedge clk);
        push_lines("1+1=", "2", 1'b0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            read_cell(e.addr, got);
            checks++;
            if (got !== e.data) begin errors++; $display("FAIL held_key_cell %0d: got %h expected %h", e.addr, got, e.data); end
        end
        tap_clear();
        @(negedge clk);
        swp = 10'b00_0010_1000;
        repeat (2*DIV) @(negedge clk);
        swp = '0;
        repeat (2*DIV) @(negedge clk);
        tap_op(8'h80); tap_digit(2);
        do_equals(-1, lat);
        push_lines("3+2=", "5", 1'b0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            read_cell(e.addr, got);
            checks++;
            if (got !== e.data) begin errors++; $display("FAIL same_strobe_cell %0d: got %h expected %h", e.addr, got, e.data); end
        end
    endtask

    task automatic test_reset_mid();
        exp_t       e;
        logic [7:0] got;
        int         lat;
        tap_clear();
        enter_number(99); tap_op(8'h20); enter_number(99);
        @(negedge clk);
        swd = 8'h08;
        for (int n = 0; n < 4*DIV && !busy; n++) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL reset_mid_busy_timeout: got %b expected 1", busy); end
        repeat (9) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (led !== 8'h00 || busy !== 1'b0) begin errors++; $display("FAIL reset_mid_out: led %h busy %b expected 00 0", led, busy); end
        checks++;
        if (char_data !== 8'h20) begin errors++; $display("FAIL reset_mid_char: got %h expected 20", char_data); end
        swd = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        push_lines("", "", 1'b0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            read_cell(e.addr, got);
            checks++;
            if (got !== e.data) begin errors++; $display("FAIL reset_mid_cell %0d: got %h expected %h", e.addr, got, e.data); end
        end
        tap_digit(3); tap_op(8'h80); tap_digit(4);
        do_equals(-1, lat);
        checks++;
        if (lat !== 28) begin errors++; $display("FAIL reentry_latency: got %0d expected 28", lat); end
        push_lines("3+4=", "7", 1'b0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            read_cell(e.addr, got);
            checks++;
            if (got !== e.data) begin errors++; $display("FAIL reentry_cell %0d: got %h expected %h", e.addr, got, e.data); end
        end
    endtask

    task automatic test_lrd_convert();
        exp_t       e;
        logic [7:0] got;
        tap_clear();
        enter_number(12); tap_op(8'h80); enter_number(34);
        @(negedge clk);
        swd = 8'h08;
        for (int n = 0; n < 4*DIV && !busy; n++) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL lrd_busy_timeout: got %b expected 1", busy); end
        repeat (4) @(negedge clk);
        lrd = 1'b1;
        for (int n = 0; n < 2*DIV && busy; n++) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || led !== 8'h00) begin errors++; $display("FAIL lrd_abort: busy %b led %h expected 0 00", busy, led); end
        lrd = 1'b0;
        swd = 8'h00;
        repeat (2*DIV) @(negedge clk);
        push_lines("", "", 1'b0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            read_cell(e.addr, got);
            checks++;
            if (got !== e.data) begin errors++; $display("FAIL lrd_cell %0d: got %h expected %h", e.addr, got, e.data); end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_mul();
        test_div();
        test_entry_edges();
        test_reset_mid();
        test_lrd_convert();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
